// File: rtl/div_arbiter.sv
// Round-robin front end for one shared iterative divider: grants a requester,
// latches its operands, runs the divider handshake and returns the tagged result.
module div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [64*N_REQ-1:0]  req_op_1_i,
  input  logic [64*N_REQ-1:0]  req_op_2_i,
  input  logic [N_REQ-1:0]     req_sign_op_1_i,
  input  logic [N_REQ-1:0]     req_sign_op_2_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic                 stall_i,
  output logic                 div_req_valid_o,
  output logic [63:0]          div_op_1_o,
  output logic [63:0]          div_op_2_o,
  output logic                 div_sign_op_1_o,
  output logic                 div_sign_op_2_o,
  output logic                 div_block_o,
  input  logic                 div_ready_i,
  input  logic                 div_valid_i,
  input  logic [63:0]          div_quotient_i,
  input  logic [63:0]          div_remainder_i,
  output logic                 resp_valid_o,
  output logic [IDW-1:0]       resp_id_o,
  output logic [63:0]          resp_quotient_o,
  output logic [63:0]          resp_remainder_o,
  input  logic                 resp_ready_i,
  output logic                 timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]  owner_reg, owner_next;
  logic [63:0]     op_1_reg, op_1_next;
  logic [63:0]     op_2_reg, op_2_next;
  logic            sign_1_reg, sign_1_next;
  logic            sign_2_reg, sign_2_next;
  logic [63:0]     quot_reg, quot_next;
  logic [63:0]     rem_reg, rem_next;
  logic [CW-1:0]   busy_cnt_reg, busy_cnt_next;
  logic            timeout_reg, timeout_next;

  logic [63:0]     op_1_arr [N_REQ];
  logic [63:0]     op_2_arr [N_REQ];
  logic [IDW-1:0]  cand_idx [N_REQ];
  logic [N_REQ-1:0] rot_valid;
  logic            win_found;
  logic [IDW-1:0]  win_idx;

  // rot_valid[i] is the request i positions after rr_ptr, so slot 0 has top priority
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign op_1_arr[gi]  = req_op_1_i[64*gi +: 64];
      assign op_2_arr[gi]  = req_op_2_i[64*gi +: 64];
      assign cand_idx[gi]  = rr_ptr_reg + IDW'(gi);
      assign rot_valid[gi] = req_valid_i[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    owner_next      = owner_reg;
    op_1_next       = op_1_reg;
    op_2_next       = op_2_reg;
    sign_1_next     = sign_1_reg;
    sign_2_next     = sign_2_reg;
    quot_next       = quot_reg;
    rem_next        = rem_reg;
    busy_cnt_next   = busy_cnt_reg;
    timeout_next    = timeout_reg;
    req_ready_o     = '0;
    div_req_valid_o = 1'b0;

    if (!stall_i) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (win_found) begin
            req_ready_o[win_idx] = 1'b1;
            owner_next  = win_idx;
            op_1_next   = op_1_arr[win_idx];
            op_2_next   = op_2_arr[win_idx];
            sign_1_next = req_sign_op_1_i[win_idx];
            sign_2_next = req_sign_op_2_i[win_idx];
            state_next  = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (div_ready_i) begin
            div_req_valid_o = 1'b1;
            busy_cnt_next   = '0;
            state_next      = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (div_valid_i) begin
            quot_next  = div_quotient_i;
            rem_next   = div_remainder_i;
            state_next = ST_RESP;
          end else if (busy_cnt_reg == CW'(TIMEOUT - 1)) begin
            // the divider never answered: drop the op and move fairness on
            timeout_next = 1'b1;
            rr_ptr_next  = owner_reg + 1'b1;
            state_next   = ST_IDLE;
          end else begin
            busy_cnt_next = busy_cnt_reg + 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            rr_ptr_next = owner_reg + 1'b1;
            state_next  = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      op_1_reg     <= '0;
      op_2_reg     <= '0;
      sign_1_reg   <= 1'b0;
      sign_2_reg   <= 1'b0;
      quot_reg     <= '0;
      rem_reg      <= '0;
      busy_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      owner_reg    <= owner_next;
      op_1_reg     <= op_1_next;
      op_2_reg     <= op_2_next;
      sign_1_reg   <= sign_1_next;
      sign_2_reg   <= sign_2_next;
      quot_reg     <= quot_next;
      rem_reg      <= rem_next;
      busy_cnt_reg <= busy_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign div_op_1_o       = op_1_reg;
  assign div_op_2_o       = op_2_reg;
  assign div_sign_op_1_o  = sign_1_reg;
  assign div_sign_op_2_o  = sign_2_reg;
  assign div_block_o      = stall_i;
  assign resp_valid_o     = (state_reg == ST_RESP);
  assign resp_id_o        = owner_reg;
  assign resp_quotient_o  = quot_reg;
  assign resp_remainder_o = rem_reg;
  assign timeout_o        = timeout_reg;

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one iterative 64-bit divider (65-bit magnitude, restoring/non-restoring core, fixed multi-cycle latency) among N_REQ requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Sequences the divider's request/ready/valid/block handshake, buffers the result, and returns it tagged with the requester id.
- Sits between the issue stage(s) and the single divider instance.

Parameters:
- N_REQ, 4, number of requesters (power of 2, 2..8).
- IDW, 2, requester id width = log2(N_REQ).
- TIMEOUT, 127, max cycles in BUSY before the error flag sets.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  N_REQ  per-requester request valid
- req_op_1_i  in  64*N_REQ  dividend, requester k at [64k+63:64k]
- req_op_2_i  in  64*N_REQ  divisor, same packing
- req_sign_op_1_i  in  N_REQ  dividend signed flag
- req_sign_op_2_i  in  N_REQ  divisor signed flag
- req_ready_o  in/out: out  N_REQ  one-hot grant, request accepted this cycle
- stall_i  in  1  global stall, freezes arbiter and divider
- div_req_valid_o  out  1  divider request valid
- div_op_1_o  out  64  latched dividend
- div_op_2_o  out  64  latched divisor
- div_sign_op_1_o  out  1  latched sign flag
- div_sign_op_2_o  out  1  latched sign flag
- div_block_o  out  1  divider freeze (= stall_i)
- div_ready_i  in  1  divider ready
- div_valid_i  in  1  divider result valid
- div_quotient_i  in  64  divider quotient
- div_remainder_i  in  64  divider remainder
- resp_valid_o  out  1  response valid
- resp_id_o  out  IDW  owner of the response
- resp_quotient_o  out  64  buffered quotient
- resp_remainder_o  out  64  buffered remainder
- resp_ready_i  in  1  response consumer ready
- timeout_o  out  1  sticky watchdog error

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- On reset: state IDLE, rr_ptr=0, all latches 0, every output 0, timeout_o=0. Reset mid-operation abandons the in-flight op; no response is produced. The divider shares the same rst.
- States and transitions:
  - IDLE:
    - Winner is the first asserted req_valid_i[k] scanning k = rr_ptr, rr_ptr+1, … mod N_REQ.
    - If a winner exists and stall_i=0: req_ready_o[k]=1 for that cycle only, latch ops/signs/owner=k, go to ISSUE.
    - req_ready_o is combinational from req_valid_i, rr_ptr and state.
  - ISSUE:
    - div_req_valid_o=1 while div_ready_i=1 and stall_i=0; that cycle is the handoff.
    - Next state BUSY; busy counter cleared.
    - If div_ready_i=0, hold ISSUE with div_req_valid_o=0.
  - BUSY:
    - div_req_valid_o=0; busy counter increments each non-stalled cycle.
    - When div_valid_i=1, capture quotient/remainder into the response buffer and go to RESP.
    - If the counter reaches TIMEOUT: set timeout_o (sticky until rst), return to IDLE, no response. rr_ptr advances as on completion.
  - RESP:
    - resp_valid_o=1; resp_id_o=owner; buffer held stable.
    - When resp_ready_i=1: go to IDLE, rr_ptr=owner+1 (wraps mod N_REQ).
    - The earliest next grant is the cycle after leaving RESP.
- Global rules:
  - Exactly one op in flight; no grants outside IDLE.
  - stall_i=1 freezes state, counter, rr_ptr and latches; div_block_o=1.
  - Outputs hold their values under stall, except req_ready_o, which is forced 0.
  - Operands pass unmodified; the arbiter does no arithmetic. Divide-by-zero results are returned as the divider produces them.
  - Latency from grant to resp_valid_o = 1 (ISSUE) + divider latency + 1 (capture), with no stalls.
  - div_op outputs are stable from ISSUE through RESP.
  - A requester deasserting req_valid_i after grant has no effect.

Test Plan:
- Directed, single requester: requester 2 only, 100/7 unsigned → grant req_ready_o=4'b0100, one-cycle div_req_valid_o, resp_id_o=2, q=14, r=2. Run with the real divider or a truncating-division model.
- Directed, signed: requester 0, -7/2 signed both → q=0xFFFF_FFFF_FFFF_FFFD (-3), r=0xFFFF_FFFF_FFFF_FFFF (-1).
- Round-robin: all 4 requesters held valid, resp_ready_i=1 → service order 0,1,2,3,0. Drop requester 1 after its service → order continues 2,3,0,2.
- Backpressure: resp_ready_i=0 for 10 cycles in RESP → resp_valid_o and data stable, no req_ready_o pulses. Release → IDLE next cycle, then the next grant.
- Stall: stall_i=1 for 5 cycles during BUSY → div_block_o=1, completion delayed exactly 5 cycles, result unchanged.
- Reset and timeout:
  - rst in BUSY → outputs 0 next cycle, no stale resp_valid_o, fresh request served normally.
  - Divider model never asserts valid → timeout_o=1 after 127 BUSY cycles, FSM back in IDLE.
